iopmp_tlul_err_responder: RTL

- Per-channel TL-UL gatekeeper that sits between one bus master and the fabric, at the enforcement end of the IOPMP checker.
- Presents each A-channel request's address and access type to the checker, then consumes the checker's iopmp_req_err verdict.
- Permitted requests pass through to the device unchanged.
- Denied requests are absorbed and answered locally with a TL-UL error response (d_error=1).
- The first violation is captured in a sticky error record and raises an interrupt.

---
 rtl/iopmp_pkg.sv | 75 +++++++
 rtl/iopmp_err_record.sv | 28 ++
 rtl/iopmp_tlul_err_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/iopmp_pkg.sv
// iopmp_pkg: TL-UL bus types and IOPMP error-responder types shared by the responder and its error record.
package iopmp_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        mubi4_t instr_type;
    } tl_a_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        IOPMP_ACC_NONE  = 2'd0,
        IOPMP_ACC_READ  = 2'd1,
        IOPMP_ACC_WRITE = 2'd2,
        IOPMP_ACC_EXEC  = 2'd3
    } iopmp_req_e;

    typedef enum logic [1:0] {IDLE, DRAIN, RESP} iopmp_resp_state_e;

    typedef struct packed {
        logic [33:0]       addr;
        iopmp_req_e        acc_type;
        logic [TL_AIW-1:0] src;
        logic [7:0]        idx;
    } iopmp_err_rec_t;

    // NONE marks an opcode the checker cannot classify; the responder rejects it outright.
    function automatic iopmp_req_e tl_to_iopmp_type(tl_a_op_e op, mubi4_t instr);
        return (op == Get) ? ((instr == MuBi4True) ? IOPMP_ACC_EXEC : IOPMP_ACC_READ) :
               (op == PutFullData || op == PutPartialData) ? IOPMP_ACC_WRITE : IOPMP_ACC_NONE;
    endfunction
endpackage

// File: rtl/iopmp_err_record.sv
// iopmp_err_record: sticky first-violation record with clear, plus a saturating violation counter.
module iopmp_err_record
    import iopmp_pkg::*;
#(
    parameter int ErrCntWidth = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_i,
    input  logic                   clr_i,
    input  iopmp_err_rec_t         rec_i,
    output logic                   valid_o,
    output iopmp_err_rec_t         rec_o,
    output logic [ErrCntWidth-1:0] cnt_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            rec_o   <= '0;
            cnt_o   <= '0;
        end else begin
            // A capture coinciding with a clear wins, so the new violation is kept.
            if (cap_i && (!valid_o || clr_i)) rec_o <= rec_i;
            valid_o <= cap_i || (valid_o && !clr_i);
            cnt_o   <= (cap_i && cnt_o != '1) ? cnt_o + 1'b1 : cnt_o;
        end
    end
endmodule

// File: rtl/iopmp_tlul_err_responder.sv
// iopmp_tlul_err_responder: TL-UL gatekeeper that forwards permitted requests and
// answers checker-denied requests locally with an in-order d_error response.
module iopmp_tlul_err_responder
    import iopmp_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int ErrCntWidth    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  tl_h2d_t                tl_h_i,
    output tl_d2h_t                tl_h_o,
    output tl_h2d_t                tl_d_o,
    input  tl_d2h_t                tl_d_i,
    output logic [33:0]            chk_addr_o,
    output iopmp_req_e             chk_type_o,
    input  logic                   chk_err_i,
    input  logic [7:0]             chk_idx_i,
    input  logic                   err_clr_i,
    output logic                   err_valid_o,
    output logic [33:0]            err_addr_o,
    output iopmp_req_e             err_type_o,
    output logic [TL_AIW-1:0]      err_src_o,
    output logic [7:0]             err_idx_o,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    output logic                   irq_o
);
    localparam int OW = $clog2(MaxOutstanding + 1);

    iopmp_resp_state_e state, state_d;
    logic [OW-1:0]     outstanding;
    logic              rsp_get;
    logic [TL_SZW-1:0] rsp_size;
    logic [TL_AIW-1:0] rsp_src;
    logic              viol, acc, pass_ok, a_fire, d_fire;
    iopmp_err_rec_t    rec_in, rec;

    assign chk_addr_o = {2'b00, tl_h_i.a_address};
    assign chk_type_o = tl_to_iopmp_type(tl_h_i.a_opcode, tl_h_i.a_user.instr_type);

    always_comb begin
        viol    = tl_h_i.a_valid && (chk_err_i || chk_type_o == IOPMP_ACC_NONE);
        acc     = state == IDLE && viol;
        pass_ok = state == IDLE && !viol && outstanding != OW'(MaxOutstanding);
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = tl_h_i.a_valid && pass_ok;
        tl_d_o.d_ready = state == RESP || tl_h_i.d_ready;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = acc || (pass_ok && tl_d_i.a_ready);
        if (state == RESP) begin
            tl_h_o.d_valid  = 1'b1;
            tl_h_o.d_opcode = rsp_get ? AccessAckData : AccessAck;
            tl_h_o.d_param  = '0;
            tl_h_o.d_size   = rsp_size;
            tl_h_o.d_source = rsp_src;
            tl_h_o.d_sink   = '0;
            tl_h_o.d_data   = '0;
            tl_h_o.d_error  = 1'b1;
        end
        a_fire  = tl_d_o.a_valid && tl_d_i.a_ready;
        d_fire  = state != RESP && tl_d_i.d_valid && tl_d_o.d_ready;
        // DRAIN waits for every forwarded response so the local error reply stays in order.
        state_d = (state == IDLE)  ? (acc ? DRAIN : IDLE) :
                  (state == DRAIN) ? ((outstanding == '0) ? RESP : DRAIN) :
                  (tl_h_i.d_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            rsp_get     <= 1'b0;
            rsp_size    <= '0;
            rsp_src     <= '0;
        end else begin
            state       <= state_d;
            outstanding <= outstanding + OW'(a_fire) - OW'(d_fire);
            if (acc) begin
                rsp_get  <= tl_h_i.a_opcode == Get;
                rsp_size <= tl_h_i.a_size;
                rsp_src  <= tl_h_i.a_source;
            end
        end
    end

    assign rec_in = '{addr: chk_addr_o, acc_type: chk_type_o, src: tl_h_i.a_source, idx: chk_idx_i};

    iopmp_err_record #(.ErrCntWidth(ErrCntWidth)) u_rec (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (acc),
        .clr_i   (err_clr_i),
        .rec_i   (rec_in),
        .valid_o (err_valid_o),
        .rec_o   (rec),
        .cnt_o   (err_cnt_o)
    );

    assign err_addr_o = rec.addr;
    assign err_type_o = rec.acc_type;
    assign err_src_o  = rec.src;
    assign err_idx_o  = rec.idx;
    assign irq_o      = err_valid_o;
endmodule
